// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns round stage with a 2-entry output buffer.
// The final round bypasses MixColumns; the round tag rides alongside the state.
module shift_mix_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  smix_valid_in,
    output logic                  smix_ready_out,
    input  logic [DATA_WIDTH-1:0] smix_data_in,
    input  logic                  smix_last_in,
    input  logic [TAG_WIDTH-1:0]  smix_tag_in,
    output logic                  smix_valid_out,
    input  logic                  smix_ready_in,
    output logic [DATA_WIDTH-1:0] smix_data_out,
    output logic [TAG_WIDTH-1:0]  smix_tag_out,
    output logic [1:0]            smix_level
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte k lives at [127-8k -: 8]; s[r][c] is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [TAG_WIDTH-1:0]  tag0_q, tag0_d;
    logic [TAG_WIDTH-1:0]  tag1_q, tag1_d;
    logic [1:0]            occ_q, occ_d;

    logic [127:0] sr;
    logic [127:0] xform;
    logic         push;
    logic         pop;

    assign smix_ready_out = rst & (occ_q != 2'd2);
    assign smix_valid_out = (occ_q != 2'd0);
    assign smix_data_out  = data0_q;
    assign smix_tag_out   = tag0_q;
    assign smix_level     = occ_q;

    always_comb begin
        sr      = shift_rows(smix_data_in);
        xform   = smix_last_in ? sr : mix_columns(sr);
        push    = smix_valid_in & smix_ready_out;
        pop     = smix_valid_out & smix_ready_in;
        data0_d = data0_q;
        data1_d = data1_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        occ_d   = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    data0_d = xform;
                    tag0_d  = smix_tag_in;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    data0_d = xform;
                    tag0_d  = smix_tag_in;
                end else if (push) begin
                    data1_d = xform;
                    tag1_d  = smix_tag_in;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    data0_d = '0;
                    tag0_d  = '0;
                    occ_d   = 2'd0;
                end
            end
            2'd2: begin
                // Full: ready_out is low, so only a pop can happen.
                if (pop) begin
                    data0_d = data1_q;
                    tag0_d  = tag1_q;
                    data1_d = '0;
                    tag1_d  = '0;
                    occ_d   = 2'd1;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data0_q <= '0;
            data1_q <= '0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            occ_q   <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_shift_mix_stage.sv
// Bench for shift_mix_stage: directed FIPS-197 vectors plus random traffic
// checked every cycle against a byte-array AES model and a queue.
module tb_shift_mix_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         smix_valid_in;
    logic         smix_ready_out;
    logic [127:0] smix_data_in;
    logic         smix_last_in;
    logic [3:0]   smix_tag_in;
    logic         smix_valid_out;
    logic         smix_ready_in;
    logic [127:0] smix_data_out;
    logic [3:0]   smix_tag_out;
    logic [1:0]   smix_level;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   t;
    } ent_t;

    ent_t q[$];
    bit   chk_en = 0;

    shift_mix_stage #(.DATA_WIDTH(128), .TAG_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .smix_valid_in(smix_valid_in),
        .smix_ready_out(smix_ready_out),
        .smix_data_in(smix_data_in),
        .smix_last_in(smix_last_in),
        .smix_tag_in(smix_tag_in),
        .smix_valid_out(smix_valid_out),
        .smix_ready_in(smix_ready_in),
        .smix_data_out(smix_data_out),
        .smix_tag_out(smix_tag_out),
        .smix_level(smix_level)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
        int acc;
        int x;
        acc = 0;
        x   = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) acc = acc ^ x;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11b;
        end
        return acc[7:0];
    endfunction

    function automatic logic [127:0] ref_xform(input logic [127:0] din, input bit last);
        logic [7:0] s[4][4];
        logic [7:0] t[4][4];
        logic [127:0] o;
        int m[4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        for (int k = 0; k < 16; k++) s[k%4][k/4] = din[127-8*k -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
        if (!last) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    s[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(t[j][c], m[r][j]);
                end
        end else begin
            s = t;
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k%4][k/4];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: advances on each rising edge from the driven inputs.
    always @(posedge clk) begin
        bit push;
        bit pop;
        if (rst !== 1'b1) begin
            q.delete();
            chk_en = 1;
        end else begin
            push = smix_valid_in && (q.size() < 2);
            pop  = (q.size() > 0) && smix_ready_in;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{ref_xform(smix_data_in, smix_last_in), smix_tag_in});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", 128'(smix_valid_out), 128'(q.size() != 0));
            check("level", 128'(smix_level), 128'(q.size()));
            check("ready_out", 128'(smix_ready_out), 128'(rst && q.size() < 2));
            check("data_out", smix_data_out, q.size() != 0 ? q[0].d : 128'h0);
            check("tag_out", 128'(smix_tag_out), q.size() != 0 ? 128'(q[0].t) : 128'h0);
        end
    end

    task automatic send(input logic [127:0] d, input bit last, input logic [3:0] t);
        bit r;
        int n;
        @(posedge clk);
        #1;
        smix_valid_in = 1'b1;
        smix_data_in  = d;
        smix_last_in  = last;
        smix_tag_in   = t;
        r = 0;
        n = 0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = smix_ready_out;
            @(posedge clk);
            n++;
        end
        #1;
        smix_valid_in = 1'b0;
        if (!r) begin
            n_total++;
            $display("FAIL send_timeout: got no ready expected ready within 50 cycles");
        end
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN   = 128'hdb135345db135345db135345db135345;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;

    initial begin
        rst           = 1'b0;
        smix_valid_in = 1'b0;
        smix_data_in  = '0;
        smix_last_in  = 1'b0;
        smix_tag_in   = '0;
        smix_ready_in = 1'b1;

        check("model_round1", ref_xform(FIPS_IN, 0), FIPS_MC);
        check("model_final", ref_xform(FIPS_IN, 1), FIPS_SR);
        check("model_column", ref_xform(COL_IN, 0), COL_OUT);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        send(FIPS_IN, 0, 4'd1);
        @(negedge clk);
        check("fips_round1", smix_data_out, FIPS_MC);
        check("fips_tag", 128'(smix_tag_out), 128'd1);
        check("fips_valid", 128'(smix_valid_out), 128'd1);

        send(FIPS_IN, 1, 4'd10);
        @(negedge clk);
        check("final_bypass", smix_data_out, FIPS_SR);

        send(COL_IN, 0, 4'd3);
        @(negedge clk);
        check("column_mix", smix_data_out, COL_OUT);

        send(128'h0, 0, 4'd4);
        @(negedge clk);
        check("zero_state", smix_data_out, 128'h0);

        // Backpressure: third push must stall until the buffer drains.
        @(posedge clk);
        #1 smix_ready_in = 1'b0;
        send(128'h00112233445566778899aabbccddeeff, 0, 4'd5);
        @(negedge clk);
        check("bp_level1", 128'(smix_level), 128'd1);
        send(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0, 4'd6);
        @(negedge clk);
        check("bp_level2", 128'(smix_level), 128'd2);
        check("bp_ready_low", 128'(smix_ready_out), 128'd0);
        fork
            send(128'hcafef00ddeadbeef0123456789abcdef, 1, 4'd7);
            begin
                repeat (4) @(posedge clk);
                #1 smix_ready_in = 1'b1;
            end
        join
        repeat (3) @(posedge clk);

        // Streaming: eight back-to-back states with the sink always ready.
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            smix_valid_in = 1'b1;
            smix_data_in  = {$urandom, $urandom, $urandom, $urandom};
            smix_last_in  = 1'(i % 3 == 0);
            smix_tag_in   = 4'(i);
            @(posedge clk);
        end
        #1 smix_valid_in = 1'b0;
        @(negedge clk);
        check("stream_level", 128'(smix_level), 128'd1);

        // Reset with two entries held.
        @(posedge clk);
        #1 smix_ready_in = 1'b0;
        @(posedge clk);
        send(128'h1, 0, 4'd8);
        send(128'h2, 0, 4'd9);
        @(negedge clk);
        check("rst_pre_level", 128'(smix_level), 128'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready_low", 128'(smix_ready_out), 128'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_valid", 128'(smix_valid_out), 128'd0);
        check("rst_level", 128'(smix_level), 128'd0);
        check("rst_data", smix_data_out, 128'h0);
        check("rst_ready_back", 128'(smix_ready_out), 128'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            smix_valid_in = 1'($urandom_range(0, 3) != 0);
            smix_ready_in = 1'($urandom_range(0, 2) != 0);
            smix_data_in  = {$urandom, $urandom, $urandom, $urandom};
            smix_last_in  = 1'($urandom_range(0, 3) == 0);
            smix_tag_in   = 4'($urandom);
            rst           = 1'($urandom_range(0, 99) != 0);
        end
        @(posedge clk);
        #1;
        smix_valid_in = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_mix_stage.md
Name: shift_mix_stage

Overview:
- Registered AES round stage that sits directly downstream of the S-box substitution stage.
- Consumes the substituted 128-bit state, applies ShiftRows, then MixColumns. MixColumns is skipped when the transfer is flagged as the final round.
- Results are held in a 2-entry output buffer with a valid/ready handshake, so the later AddRoundKey stage can apply backpressure without losing data.
- A round tag travels alongside the data for the round controller.

Parameters:
- DATA_WIDTH, 128, state width in bits; only 128 is supported.
- TAG_WIDTH, 4, width of the round tag carried with each state.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous active-low reset
- smix_valid_in  input  1  upstream state and tag are valid
- smix_ready_out  output  1  stage can accept a transfer this cycle
- smix_data_in  input  DATA_WIDTH  substituted state from the S-box stage
- smix_last_in  input  1  final round: bypass MixColumns
- smix_tag_in  input  TAG_WIDTH  round number, passed through unchanged
- smix_valid_out  output  1  head entry is valid
- smix_ready_in  input  1  downstream accepts the head entry
- smix_data_out  output  DATA_WIDTH  transformed state (head entry)
- smix_tag_out  output  TAG_WIDTH  tag of the head entry
- smix_level  output  2  buffer occupancy, 0 to 2

Behaviour:
- Reset
  - Reset is synchronous, active-low, one clock.
  - While rst=0 at a rising edge: occupancy=0, smix_valid_out=0, smix_data_out=0, smix_tag_out=0, smix_level=0, both buffer entries cleared.
  - smix_ready_out=0 while rst=0.
  - Reset asserted mid-operation discards all held entries. No partial output is produced.
- Byte order
  - State byte k (k=0..15) is data[127-8k -: 8].
  - s[r][c] is byte 4c+r (column-major, FIPS-197).
- ShiftRows
  - s'[r][c] = s[r][(c+r) mod 4].
  - Row 0 is unchanged; row r rotates left by r.
- MixColumns
  - Per column over GF(2^8) with polynomial 0x11B.
  - s'0 = 2a0^3a1^a2^a3; s'1 = a0^2a1^3a2^a3; s'2 = a0^a1^2a2^3a3; s'3 = 3a0^a1^a2^2a3.
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0), truncated to 8 bits.
- Datapath timing
  - The transform is combinational on the input side. The result and tag are written into the buffer at the accepting edge.
  - There is no storage before the transform.
- Handshake
  - A transfer in occurs at a rising edge where smix_valid_in=1 and smix_ready_out=1.
  - A transfer out occurs where smix_valid_out=1 and smix_ready_in=1.
  - smix_ready_out = rst & (occupancy<2), decoded from registered occupancy only. There is no combinational path from smix_ready_in.
- Latency and throughput
  - A state accepted at edge N appears on smix_data_out from edge N (visible in cycle N+1) if the buffer was empty.
  - Otherwise it appears once the entries ahead of it drain.
  - Minimum latency is 1 cycle. Throughput is 1 state per cycle while smix_ready_in=1.
- Buffer organisation
  - 2-entry FIFO with entry 0 as head.
  - smix_data_out and smix_tag_out always drive entry 0. They are 0 when empty.
  - Data order is strictly preserved.
- Occupancy updates
  - Push only: +1.
  - Pop only: -1, and entry 1 shifts to entry 0.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1, entry 0 takes the new result.
  - Push at occupancy 2 is impossible because ready_out=0.
  - Pop at occupancy 0 is ignored because valid_out=0.
- Output rules
  - smix_valid_out = (occupancy!=0).
  - Head data and tag stay stable while valid_out=1 and ready_in=0.
  - smix_level equals occupancy.
- Input rules
  - smix_last_in and smix_tag_in are sampled only on a transfer in.
  - Inputs while valid_in=0 are ignored.

Test Plan:
- FIPS-197 round 1: data_in=d42711aee0bf98f1b8b45de51e415230, last=0, tag=1, ready_in=1 -> next cycle data_out=046681e5e0cb199a48f8d37a2806264c, tag_out=1, valid_out=1.
- Final-round bypass: same data_in with last=1 -> data_out=d4bf5d30e0b452aeb84111f11e2798e5 (ShiftRows only).
- Single-column MixColumns: column db135345 in every column, last=0 -> each output column is 8e4da1bc. Input all-zero -> output all-zero.
- Backpressure: ready_in=0, push 3 states back-to-back -> level goes 1, 2; ready_out=0 after the 2nd. Then ready_in=1 -> the first two states are output in order. The third state is accepted only once ready_out returns to 1.
- Streaming: ready_in=1, push 8 states on consecutive cycles -> 8 outputs on consecutive cycles, each exactly one cycle after its input, level never exceeds 1.
- Reset mid-operation: level=2, drive rst=0 for one edge -> valid_out=0, level=0, data_out=0, ready_out=0 during reset. ready_out=1 on the cycle after rst returns to 1.
